// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/wait/respond sequencer in front of alu_4bit.
// One command in flight; a WAIT-state timer forces a response if Done never comes.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_a,
  input  logic [3:0]                 cmd_b,
  input  logic [1:0]                 cmd_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [1:0]                 alu_opcode,
  output logic                       alu_start,
  input  logic [7:0]                 alu_result,
  input  logic                       alu_done,
  input  logic                       alu_error,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_result,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          expire;
  logic [TW-1:0] timer;
  state_t        state_q;
  state_t        state_d;

  assign cmd_ready = fifo_count < CW'(DEPTH);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) && (fifo_count != '0);
  assign head      = mem[rd_ptr];
  assign expire    = timer == TW'(TIMEOUT - 1);

  assign alu_start = state_q == ISSUE;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;

  // Storage needs no reset: count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_done || expire) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer counts completed WAIT cycles; expiry on the TIMEOUT-th one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      timer       <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
      end
      if (state_q == ISSUE) timer <= '0;
      if (state_q == WAIT) begin
        if (alu_done) begin
          rsp_result  <= alu_result;
          rsp_error   <= alu_error;
          rsp_timeout <= 1'b0;
        end else if (expire) begin
          rsp_result  <= '0;
          rsp_error   <= 1'b0;
          rsp_timeout <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 1-cycle ALU.
// Responses are logged as {timeout, error, result} and compared in order.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_opcode;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       alu_error;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_error;
  logic       rsp_timeout;
  logic       busy;
  logic [2:0] fifo_count;

  logic model_done;
  logic hang;
  logic inj_done;

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  bit   saw_full = 0;
  logic [9:0] rsp_q [$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  assign alu_done = model_done | inj_done;

  // Behavioural ALU: Done one cycle after start unless hung
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset && alu_start && !hang) begin
      model_done <= 1'b1;
      alu_error  <= 1'b0;
      case (alu_opcode)
        2'd0: alu_result <= {4'd0, alu_a} + {4'd0, alu_b};
        2'd1: alu_result <= {4'd0, alu_a} - {4'd0, alu_b};
        2'd2: alu_result <= {4'd0, alu_a} * {4'd0, alu_b};
        default: begin
          if (alu_b == 4'd0) begin
            alu_result <= 8'd0;
            alu_error  <= 1'b1;
          end else begin
            alu_result <= {4'd0, alu_a / alu_b};
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (alu_start) n_starts++;
      if (rsp_valid && rsp_ready)
        rsp_q.push_back({rsp_timeout, rsp_error, rsp_result});
      if (fifo_count == 3'd4 && !cmd_ready) saw_full = 1;
      n_tests++;
      if (cmd_ready !== (fifo_count < 3'd4)) begin
        n_fail++;
        $display("FAIL cmd_ready_vs_count: got %0b with count %0d",
                 cmd_ready, fifo_count);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
    bit acc = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got not accepted, expected accepted");
    end
  endtask

  task automatic wait_rsp(input int n, input string name);
    for (int i = 0; i < 300 && rsp_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (rsp_q.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d responses, expected %0d",
               name, rsp_q.size(), n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         s0;
    int         cnt;
    bit         ok;
    bit         stable;
    logic [5:0] st_bits;
    logic [5:0] rv_bits;
    logic [9:0] r4;
    logic [7:0] r0;

    tbl[0] = '{4'd5,  4'd3, 2'd0, 10'h008};
    tbl[1] = '{4'd10, 4'd4, 2'd1, 10'h006};
    tbl[2] = '{4'd5,  4'd3, 2'd2, 10'h00F};
    tbl[3] = '{4'd10, 4'd2, 2'd3, 10'h005};
    tbl[4] = '{4'd7,  4'd1, 2'd0, 10'h008};
    tbl[5] = '{4'd8,  4'd0, 2'd3, 10'h100};

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    rsp_ready  = 1'b1;
    hang       = 1'b0;
    inj_done   = 1'b0;
    model_done = 1'b0;
    alu_result = '0;
    alu_error  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        32'({alu_a, alu_b, alu_opcode, alu_start, rsp_valid, rsp_result,
             rsp_error, rsp_timeout, busy, fifo_count, cmd_ready}), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Test 1: latency of a single ADD
    s0   = n_starts;
    base = rsp_q.size();
    @(posedge clk);
    #1;
    cmd_a = 4'd5; cmd_b = 4'd3; cmd_op = 2'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    st_bits = '0;
    rv_bits = '0;
    r4      = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      st_bits[c] = alu_start;
      rv_bits[c] = rsp_valid;
      if (c == 4) r4 = {rsp_timeout, rsp_error, rsp_result};
      @(posedge clk);
      #1;
    end
    chk("t1_start_cycle", 32'(st_bits), 32'h04);
    chk("t1_valid_cycle", 32'(rv_bits), 32'h10);
    chk("t1_rsp_fields", 32'(r4), 32'h008);
    chk("t1_start_count", 32'(n_starts - s0), 32'd1);

    // Tests 2 and 3: back-to-back table, including divide by zero
    s0       = n_starts;
    base     = rsp_q.size();
    saw_full = 0;
    for (int i = 0; i < 6; i++) push_cmd(tbl[i].a, tbl[i].b, tbl[i].op);
    cmd_valid = 1'b0;
    wait_rsp(base + 6, "t2_drain");
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_rsp_%0d", i), 32'(rsp_q[base+i]), 32'(tbl[i].exp));
    chk("t2_start_count", 32'(n_starts - s0), 32'd6);
    chk("t2_saw_full", 32'(saw_full), 32'd1);

    // Test 4: response backpressure with two queued
    rsp_ready = 1'b0;
    s0        = n_starts;
    base      = rsp_q.size();
    push_cmd(4'd1, 4'd2, 2'd0);
    push_cmd(4'd9, 4'd3, 2'd1);
    push_cmd(4'd3, 4'd4, 2'd2);
    cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("t4_valid_seen", 32'(ok), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd2);
    r0     = rsp_result;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_result == r0 && fifo_count == 3'd2 &&
            n_starts == s0 + 1))
        stable = 0;
    end
    chk("t4_stall_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp(base + 3, "t4_drain");
    chk("t4_rsp_0", 32'(rsp_q[base]),   32'h003);
    chk("t4_rsp_1", 32'(rsp_q[base+1]), 32'h006);
    chk("t4_rsp_2", 32'(rsp_q[base+2]), 32'h00C);
    chk("t4_start_count", 32'(n_starts - s0), 32'd3);

    // Test 5: hung ALU, then late Done, then normal command
    hang      = 1'b1;
    rsp_ready = 1'b0;
    s0        = n_starts;
    base      = rsp_q.size();
    push_cmd(4'd2, 4'd2, 2'd0);
    cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = alu_start;
    end
    cnt = 0;
    ok  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cnt++;
      ok = rsp_valid;
    end
    chk("t5_wait_cycles", 32'(cnt - 1), 32'd15);
    chk("t5_timeout_fields",
        32'({rsp_timeout, rsp_error, rsp_result}), 32'h200);
    @(posedge clk);
    #1 inj_done = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b0;
    @(negedge clk);
    chk("t5_late_done_resp",
        32'({rsp_valid, rsp_timeout, rsp_error, rsp_result}), 32'h600);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b0;
    @(negedge clk);
    chk("t5_late_done_idle", 32'({busy, rsp_valid}), 32'd0);
    @(posedge clk);
    #1 hang = 1'b0;
    push_cmd(4'd4, 4'd5, 2'd0);
    cmd_valid = 1'b0;
    wait_rsp(base + 2, "t5_drain");
    chk("t5_rsp_timeout", 32'(rsp_q[base]),   32'h200);
    chk("t5_rsp_next",    32'(rsp_q[base+1]), 32'h009);
    chk("t5_start_count", 32'(n_starts - s0), 32'd2);

    // Test 6: asynchronous reset mid-WAIT with three queued
    hang = 1'b1;
    push_cmd(4'd1, 4'd1, 2'd0);
    push_cmd(4'd2, 4'd2, 2'd0);
    push_cmd(4'd3, 4'd3, 2'd0);
    push_cmd(4'd4, 4'd4, 2'd0);
    cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = (fifo_count == 3'd3) && busy && !alu_start && !rsp_valid;
    end
    chk("t6_reached_wait", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_outputs",
        32'({alu_a, alu_b, alu_opcode, alu_start, rsp_valid, rsp_result,
             rsp_error, rsp_timeout, busy, fifo_count, cmd_ready}), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    hang  = 1'b0;
    s0    = n_starts;
    base  = rsp_q.size();
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("t6_no_start_after", 32'(n_starts - s0), 32'd0);
    chk("t6_idle_after", 32'({busy, fifo_count}), 32'd0);
    push_cmd(4'd6, 4'd1, 2'd0);
    cmd_valid = 1'b0;
    wait_rsp(base + 1, "t6_drain");
    chk("t6_rsp_new", 32'(rsp_q[base]), 32'h007);
    chk("t6_start_count", 32'(n_starts - s0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command/response sequencer for alu_4bit. It accepts operand/opcode commands over a valid/ready interface and queues them in a small FIFO. For each command it drives the ALU operands with a one-cycle start pulse, waits for Done, then presents Result/Error downstream over a valid/ready response interface. One command is in flight at a time, with a timeout guard against a hung ALU.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TIMEOUT, 15, maximum cycles spent in WAIT before a timeout response is forced; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command FIFO can accept a command.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
cmd_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
alu_a  output  4  to ALU A.
alu_b  output  4  to ALU B.
alu_opcode  output  2  to ALU opcode.
alu_start  output  1  one-cycle start pulse to the ALU.
alu_result  input  8  ALU Result.
alu_done  input  1  ALU Done.
alu_error  input  1  ALU Error (divide by zero).
rsp_valid  output  1  response available.
rsp_ready  input  1  downstream accepts the response.
rsp_result  output  8  captured result.
rsp_error  output  1  captured ALU error.
rsp_timeout  output  1  ALU did not respond within TIMEOUT.
busy  output  1  state is not IDLE.
fifo_count  output  clog2(DEPTH+1)  number of queued commands.

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied and pointers zeroed; state=IDLE. All outputs are 0 except cmd_ready, which is 1 once the FIFO is empty. Reset mid-operation discards the in-flight and queued commands.
- FIFO: cmd_ready = (fifo_count < DEPTH). A push occurs on cmd_valid & cmd_ready. There is no bypass when full: a push and a pop in the same cycle are both legal, and fifo_count is then unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into the operand registers (alu_a/alu_b/alu_opcode), then go to ISSUE.
  - ISSUE: alu_start=1 for exactly this cycle; clear the timer; go to WAIT.
  - WAIT: on alu_done=1, capture alu_result→rsp_result and alu_error→rsp_error, set rsp_timeout=0, go to RESP. Otherwise increment the timer; when timer==TIMEOUT, set rsp_result=0, rsp_error=0, rsp_timeout=1 and go to RESP.
  - RESP: rsp_valid=1. Response fields hold stable until rsp_ready=1, at which point the response is consumed and the state returns to IDLE.
- alu_a/alu_b/alu_opcode are held stable from ISSUE through the end of RESP.
- alu_done is sampled only in WAIT. A Done in any other state (including a late Done after a timeout) is ignored.
- Latency, with an empty FIFO, an IDLE sequencer and a 1-cycle ALU:
  - command accepted in cycle 0;
  - alu_start high in cycle 2;
  - alu_done observed in cycle 3;
  - rsp_valid high in cycle 4.
- Throughput: with rsp_ready=1 held, one command completes every 4 cycles.
- Responses are delivered in command order; exactly one alu_start is issued per command.
- Commands continue to be accepted while a command is in WAIT or RESP.

Test Plan:
1. Single ADD (A=5, B=3, op=00) into a behavioural 1-cycle ALU model, rsp_ready=1 → alu_start pulses in cycle 2 only; rsp_valid in cycle 4 with rsp_result=8, rsp_error=0, rsp_timeout=0.
2. Five back-to-back commands (5+3, 10-4, 5*3, 10/2, 7+1) with cmd_valid held → cmd_ready falls while fifo_count=4; all five are eventually accepted; responses are 8, 6, 15, 5, 8 in order; exactly 5 alu_start pulses.
3. DIV 8/0 with the model asserting Error → rsp_result=0, rsp_error=1, rsp_timeout=0.
4. rsp_ready=0 for 10 cycles with 2 commands queued → rsp_valid and rsp_result stay stable, no new alu_start, fifo_count=2 unchanged; releasing rsp_ready drains both in order.
5. ALU model never asserts Done → exactly TIMEOUT=15 WAIT cycles, then rsp_valid with rsp_timeout=1, rsp_result=0; a Done injected afterwards is ignored and the next command completes normally.
6. Assert reset mid-WAIT with 3 commands queued → all outputs 0 immediately (asynchronously), fifo_count=0; after release, no alu_start occurs until a new command is pushed.
